dm_arbiter: RTL

- Two-port arbiter and access sequencer for the byte-array data memory (DM) of the multicycle CPU.
- Port 0 is the CPU MEM stage; port 1 is a debug/DMA loader.
- Grants one requester at a time with round-robin fairness. Latches the request and drives DM address, write data and write strobe through a fixed state sequence.
- The DM write strobe is level/change-sensitive, so it is asserted for exactly one clock with address and data stable before, during and after it.

---
 rtl/dm_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the byte-array data memory.
// Each access walks IDLE -> SETUP -> (STROBE) -> DONE with address/data held stable around a one-cycle write strobe.
module dm_arbiter #(
  parameter int unsigned DEPTH       = 128,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        done0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        done1,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] MAX_ADDR = 32'(DEPTH - 32'd4);

  state_e      state_q;
  logic        port_q;
  logic        we_q;
  logic        last_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_rw_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        done0_q;
  logic        done1_q;
  logic        err0_q;
  logic        err1_q;
  logic        busy_q;

  logic        gnt_valid_d;
  logic        gnt_port_d;
  logic        gnt_we_d;
  logic [31:0] gnt_addr_d;
  logic [31:0] gnt_wdata_d;
  logic        access_err;

  // Winner selection: a tie goes to the port that was not served last.
  always_comb begin
    gnt_valid_d = 1'b0;
    gnt_port_d  = 1'b0;
    if (req0 && req1) begin
      gnt_valid_d = 1'b1;
      gnt_port_d  = ~last_q;
    end else if (req0) begin
      gnt_valid_d = 1'b1;
      gnt_port_d  = 1'b0;
    end else if (req1) begin
      gnt_valid_d = 1'b1;
      gnt_port_d  = 1'b1;
    end else begin
      gnt_valid_d = 1'b0;
      gnt_port_d  = 1'b0;
    end
  end

  // Request fields of the winning port, latched on grant.
  always_comb begin
    gnt_we_d    = 1'b0;
    gnt_addr_d  = 32'h0000_0000;
    gnt_wdata_d = 32'h0000_0000;
    if (gnt_port_d) begin
      gnt_we_d    = we1;
      gnt_addr_d  = addr1;
      gnt_wdata_d = wdata1;
    end else begin
      gnt_we_d    = we0;
      gnt_addr_d  = addr0;
      gnt_wdata_d = wdata0;
    end
  end

  // Latched address is rejected when misaligned or when the word would run past the array end.
  always_comb begin
    access_err = 1'b0;
    if (mem_addr_q > MAX_ADDR) begin
      access_err = 1'b1;
    end else if (CHECK_ALIGN && (mem_addr_q[1:0] != 2'b00)) begin
      access_err = 1'b1;
    end else begin
      access_err = 1'b0;
    end
  end

  // Access sequencer with registered memory-side and requester-side outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      last_q      <= 1'b1;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_rw_q    <= 1'b0;
      rdata0_q    <= 32'h0000_0000;
      rdata1_q    <= 32'h0000_0000;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_rw_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            port_q      <= gnt_port_d;
            last_q      <= gnt_port_d;
            we_q        <= gnt_we_d;
            mem_addr_q  <= gnt_addr_d;
            mem_wdata_q <= gnt_wdata_d;
            busy_q      <= 1'b1;
            state_q     <= SETUP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SETUP: begin
          if (access_err) begin
            state_q <= DONE;
            if (port_q) begin
              rdata1_q <= 32'h0000_0000;
              err1_q   <= 1'b1;
              done1_q  <= 1'b1;
            end else begin
              rdata0_q <= 32'h0000_0000;
              err0_q   <= 1'b1;
              done0_q  <= 1'b1;
            end
          end else if (we_q) begin
            mem_rw_q <= 1'b1;
            state_q  <= STROBE;
          end else begin
            state_q <= DONE;
            if (port_q) begin
              rdata1_q <= mem_rdata;
              done1_q  <= 1'b1;
            end else begin
              rdata0_q <= mem_rdata;
              done0_q  <= 1'b1;
            end
          end
        end
        STROBE: begin
          state_q <= DONE;
          if (port_q) begin
            done1_q <= 1'b1;
          end else begin
            done0_q <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = mem_rw_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign busy      = busy_q;

endmodule
